// File: rtl/mlp_act_pingpong_mem_if.sv
// Bus bundle between the activation/weight store and its host loader and MAC array.
// The store uses the slave modport; the host/MAC side uses the master modport.
interface mlp_act_pingpong_mem_if #(
   parameter int L  = 2,
   parameter int N  = 2,
   parameter int QM = 3,
   parameter int QN = 5,
   parameter int WM = 3,
   parameter int WN = 5
);
   localparam int AW  = QM + QN;
   localparam int WW  = WM + WN;
   localparam int NLW = $clog2(L + 1);
   localparam int LIW = (L > 1) ? $clog2(L) : 1;

   // host load channel
   logic                                  load_valid;
   logic                                  load_ready;
   logic [N-1:0][AW-1:0]                  x;
   logic [L-1:0][N-1:0][N-1:0][WW-1:0]    w;
   logic [L-1:0][N-1:0][AW-1:0]           b;

   // run control
   logic                                  start;
   logic [NLW-1:0]                        num_layers;

   // operand read channel towards the MAC
   logic                                  rd_valid;
   logic                                  rd_ready;
   logic [N-1:0][AW-1:0]                  inputs;
   logic [N-1:0][N-1:0][WW-1:0]           weights;
   logic [N-1:0][AW-1:0]                  bias;

   // result write channel from the MAC
   logic                                  wr_valid;
   logic                                  wr_ready;
   logic [N-1:0][AW-1:0]                  result;

   // status
   logic [LIW-1:0]                        layer_idx;
   logic                                  busy;
   logic                                  done;
   logic                                  err;
   logic [N-1:0][AW-1:0]                  y;

   modport slave (
      input  load_valid, x, w, b, start, num_layers, rd_ready, wr_valid, result,
      output load_ready, rd_valid, inputs, weights, bias, wr_ready,
             layer_idx, busy, done, err, y
   );

   modport master (
      output load_valid, x, w, b, start, num_layers, rd_ready, wr_valid, result,
      input  load_ready, rd_valid, inputs, weights, bias, wr_ready,
             layer_idx, busy, done, err, y
   );
endinterface

// File: rtl/mlp_act_pingpong_mem.sv
// Layer-serial MLP activation/weight store: holds weights, biases and two
// activation banks, and sequences layers towards the MAC array with
// valid/ready handshakes. Results of hidden layers may be ReLU'd.
module mlp_act_pingpong_mem #(
   parameter int L    = 2,
   parameter int N    = 2,
   parameter int QM   = 3,
   parameter int QN   = 5,
   parameter int WM   = 3,
   parameter int WN   = 5,
   parameter int RELU = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   mlp_act_pingpong_mem_if.slave   bus
);
   localparam int AW  = QM + QN;
   localparam int WW  = WM + WN;
   localparam int NLW = $clog2(L + 1);
   localparam int LIW = (L > 1) ? $clog2(L) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                         state_reg;
   logic                               sel_reg;
   logic [LIW-1:0]                     layer_idx_reg;
   logic [NLW-1:0]                     num_layers_reg;
   logic                               err_reg;

   // x_reg keeps the loaded network input so every run can restart from it,
   // even though the final layer of a two-layer run lands back in bank0.
   logic [N-1:0][AW-1:0]               x_reg;
   logic [N-1:0][AW-1:0]               bank0_reg;
   logic [N-1:0][AW-1:0]               bank1_reg;
   logic [N-1:0][AW-1:0]               y_reg;
   logic [L-1:0][N-1:0][N-1:0][WW-1:0] w_reg;
   logic [L-1:0][N-1:0][AW-1:0]        b_reg;

   logic                               load_fire;
   logic                               start_fire;
   logic                               start_ok;
   logic                               wr_fire;
   logic                               last_layer;
   logic [N-1:0][AW-1:0]               relu_result;
   logic [N-1:0][AW-1:0]               wr_data;

   // A load in the same cycle as start wins; start is then ignored.
   assign load_fire  = (state_reg == S_IDLE) && bus.load_valid;
   assign start_fire = (state_reg == S_IDLE) && !bus.load_valid && bus.start;
   assign start_ok   = (bus.num_layers != '0) && (int'(bus.num_layers) <= L);
   assign wr_fire    = (state_reg == S_WAIT) && bus.wr_valid;
   assign last_layer = (int'(layer_idx_reg) == int'(num_layers_reg) - 1);

   // ReLU is a pure sign-bit test: negative elements become zero.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_relu
         assign relu_result[gi] = bus.result[gi][AW-1] ? '0 : bus.result[gi];
      end
   endgenerate

   // The final layer is never rectified.
   assign wr_data = ((RELU != 0) && !last_layer) ? relu_result : bus.result;

   // Layer sequencer: IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         sel_reg        <= 1'b0;
         layer_idx_reg  <= '0;
         num_layers_reg <= '0;
         err_reg        <= 1'b0;
      end else begin
         err_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (load_fire) begin
                  sel_reg <= 1'b0;
               end else if (start_fire) begin
                  if (start_ok) begin
                     num_layers_reg <= bus.num_layers;
                     layer_idx_reg  <= '0;
                     sel_reg        <= 1'b0;
                     state_reg      <= S_ISSUE;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (bus.rd_ready) begin
                  state_reg <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.wr_valid) begin
                  sel_reg <= ~sel_reg;
                  if (last_layer) begin
                     state_reg <= S_DONE;
                  end else begin
                     layer_idx_reg <= layer_idx_reg + LIW'(1);
                     state_reg     <= S_ISSUE;
                  end
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // Data stores: host load, bank0 restore at start, ping-pong result writes, final y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg     <= '0;
         bank0_reg <= '0;
         bank1_reg <= '0;
         y_reg     <= '0;
         w_reg     <= '0;
         b_reg     <= '0;
      end else begin
         if (load_fire) begin
            x_reg     <= bus.x;
            bank0_reg <= bus.x;
            w_reg     <= bus.w;
            b_reg     <= bus.b;
         end else if (start_fire && start_ok) begin
            bank0_reg <= x_reg;
         end
         if (wr_fire) begin
            if (sel_reg) begin
               bank0_reg <= wr_data;
            end else begin
               bank1_reg <= wr_data;
            end
            if (last_layer) begin
               y_reg <= bus.result;
            end
         end
      end
   end

   assign bus.load_ready = (state_reg == S_IDLE);
   assign bus.rd_valid   = (state_reg == S_ISSUE);
   assign bus.wr_ready   = (state_reg == S_WAIT);
   assign bus.busy       = (state_reg != S_IDLE);
   assign bus.done       = (state_reg == S_DONE);
   assign bus.err        = err_reg;
   assign bus.layer_idx  = layer_idx_reg;
   assign bus.y          = y_reg;
   assign bus.inputs     = sel_reg ? bank1_reg : bank0_reg;
   assign bus.weights    = w_reg[layer_idx_reg];
   assign bus.bias       = b_reg[layer_idx_reg];
endmodule

// File: tb/tb_mlp_act_pingpong_mem.sv
// Self-checking bench: one RELU=1 and one RELU=0 store driven with identical
// stimulus; a behavioural model of the layer chain predicts operands and y.
module tb_mlp_act_pingpong_mem;
   localparam int L   = 2;
   localparam int N   = 2;
   localparam int QM  = 3;
   localparam int QN  = 5;
   localparam int WM  = 3;
   localparam int WN  = 5;
   localparam int AW  = QM + QN;
   localparam int WW  = WM + WN;
   localparam int NLW = $clog2(L + 1);
   localparam int LIW = (L > 1) ? $clog2(L) : 1;

   typedef logic [N-1:0][AW-1:0]        vec_t;
   typedef logic [N-1:0][N-1:0][WW-1:0] wmat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // shared stimulus
   logic                               load_valid;
   logic                               start;
   logic                               rd_ready;
   logic                               wr_valid;
   logic [NLW-1:0]                     num_layers;
   vec_t                               x;
   vec_t                               result;
   logic [L-1:0][N-1:0][N-1:0][WW-1:0] w;
   logic [L-1:0][N-1:0][AW-1:0]        b;

   mlp_act_pingpong_mem_if #(.L(L), .N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN)) bus_r ();
   mlp_act_pingpong_mem_if #(.L(L), .N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN)) bus_p ();

   mlp_act_pingpong_mem #(.L(L), .N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN), .RELU(1))
      dut_relu (.clk(clk), .rst(rst), .bus(bus_r));
   mlp_act_pingpong_mem #(.L(L), .N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN), .RELU(0))
      dut_pass (.clk(clk), .rst(rst), .bus(bus_p));

   assign bus_r.load_valid = load_valid;
   assign bus_r.start      = start;
   assign bus_r.rd_ready   = rd_ready;
   assign bus_r.wr_valid   = wr_valid;
   assign bus_r.num_layers = num_layers;
   assign bus_r.x          = x;
   assign bus_r.w          = w;
   assign bus_r.b          = b;
   assign bus_r.result     = result;
   assign bus_p.load_valid = load_valid;
   assign bus_p.start      = start;
   assign bus_p.rd_ready   = rd_ready;
   assign bus_p.wr_valid   = wr_valid;
   assign bus_p.num_layers = num_layers;
   assign bus_p.x          = x;
   assign bus_p.w          = w;
   assign bus_p.b          = b;
   assign bus_p.result     = result;

   // observed outputs, index 0 = RELU store, 1 = pass-through store
   logic [1:0]     load_ready_o, rd_valid_o, wr_ready_o, busy_o, done_o, err_o;
   vec_t           inputs_o [2];
   vec_t           bias_o [2];
   vec_t           y_o [2];
   wmat_t          weights_o [2];
   logic [LIW-1:0] layer_idx_o [2];

   assign load_ready_o   = {bus_p.load_ready, bus_r.load_ready};
   assign rd_valid_o     = {bus_p.rd_valid, bus_r.rd_valid};
   assign wr_ready_o     = {bus_p.wr_ready, bus_r.wr_ready};
   assign busy_o         = {bus_p.busy, bus_r.busy};
   assign done_o         = {bus_p.done, bus_r.done};
   assign err_o          = {bus_p.err, bus_r.err};
   assign inputs_o[0]    = bus_r.inputs;
   assign inputs_o[1]    = bus_p.inputs;
   assign bias_o[0]      = bus_r.bias;
   assign bias_o[1]      = bus_p.bias;
   assign y_o[0]         = bus_r.y;
   assign y_o[1]         = bus_p.y;
   assign weights_o[0]   = bus_r.weights;
   assign weights_o[1]   = bus_p.weights;
   assign layer_idx_o[0] = bus_r.layer_idx;
   assign layer_idx_o[1] = bus_p.layer_idx;

   // reference model: what the host last loaded, per-layer MAC answers, expected y
   vec_t  mx;
   wmat_t mw [L];
   vec_t  mb [L];
   vec_t  res_tab [L];
   vec_t  ey [2];
   vec_t  prev_y;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t relu(input vec_t v);
      vec_t r;
      for (int i = 0; i < N; i++) begin
         r[i] = ($signed(v[i]) < 0) ? '0 : v[i];
      end
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t r;
      for (int i = 0; i < N; i++) begin
         r[i] = AW'($urandom());
      end
      return r;
   endfunction

   task automatic rand_wb();
      for (int l = 0; l < L; l++) begin
         for (int n = 0; n < N; n++) begin
            b[l][n] = AW'($urandom());
            for (int i = 0; i < N; i++) begin
               w[l][n][i] = WW'($urandom());
            end
         end
      end
   endtask

   task automatic model_take_load();
      mx = x;
      for (int l = 0; l < L; l++) begin
         mw[l] = w[l];
         mb[l] = b[l];
      end
   endtask

   task automatic load_now();
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      model_take_load();
      $display("load x=%0h", x);
   endtask

   task automatic rand_results();
      for (int l = 0; l < L; l++) begin
         res_tab[l] = rand_vec();
      end
   endtask

   task automatic check_operands(input string tag, input int k, input vec_t act [2]);
      for (int v = 0; v < 2; v++) begin
         check_eq($sformatf("%s_rd_valid%0d_l%0d", tag, v, k), 64'(rd_valid_o[v]), 64'(1));
         check_eq($sformatf("%s_layer_idx%0d_l%0d", tag, v, k), 64'(layer_idx_o[v]), 64'(k));
         check_eq($sformatf("%s_inputs%0d_l%0d", tag, v, k), 64'(inputs_o[v]), 64'(act[v]));
         check_eq($sformatf("%s_weights%0d_l%0d", tag, v, k), 64'(weights_o[v]), 64'(mw[k]));
         check_eq($sformatf("%s_bias%0d_l%0d", tag, v, k), 64'(bias_o[v]), 64'(mb[k]));
      end
   endtask

   // One full inference of nl layers, answering with res_tab[k] for layer k.
   task automatic run(input int nl, input int stall, input bit poke_wr, input bit poke_load);
      vec_t act [2];
      start      = 1'b1;
      num_layers = NLW'(nl);
      step();
      start  = 1'b0;
      act[0] = mx;
      act[1] = mx;
      for (int k = 0; k < nl; k++) begin
         check_operands("issue", k, act);
         for (int s = 0; s < stall; s++) begin
            wr_valid = poke_wr && (s == stall / 2);
            step();
            wr_valid = 1'b0;
         end
         if (stall > 0) check_operands("stall", k, act);
         rd_ready = 1'b1;
         step();
         rd_ready = 1'b0;
         for (int v = 0; v < 2; v++) begin
            check_eq($sformatf("wait_wr_ready%0d_l%0d", v, k), 64'(wr_ready_o[v]), 64'(1));
            check_eq($sformatf("wait_rd_valid%0d_l%0d", v, k), 64'(rd_valid_o[v]), 64'(0));
            check_eq($sformatf("wait_load_ready%0d_l%0d", v, k), 64'(load_ready_o[v]), 64'(0));
         end
         if (poke_load) begin
            x          = rand_vec();
            load_valid = 1'b1;
            step();
            load_valid = 1'b0;
         end
         result   = res_tab[k];
         wr_valid = 1'b1;
         step();
         wr_valid = 1'b0;
         if (k < nl - 1) begin
            act[0] = relu(res_tab[k]);
            act[1] = res_tab[k];
         end else begin
            ey[0] = res_tab[k];
            ey[1] = res_tab[k];
         end
      end
      for (int v = 0; v < 2; v++) begin
         check_eq($sformatf("done_pulse%0d", v), 64'(done_o[v]), 64'(1));
         check_eq($sformatf("done_busy%0d", v), 64'(busy_o[v]), 64'(1));
      end
      step();
      for (int v = 0; v < 2; v++) begin
         check_eq($sformatf("done_low%0d", v), 64'(done_o[v]), 64'(0));
         check_eq($sformatf("idle_busy%0d", v), 64'(busy_o[v]), 64'(0));
         check_eq($sformatf("y%0d", v), 64'(y_o[v]), 64'(ey[v]));
      end
      $display("run layers=%0d stall=%0d y_relu=%0h y_pass=%0h", nl, stall, y_o[0], y_o[1]);
   endtask

   task automatic bad_start(input int nl);
      start      = 1'b1;
      num_layers = NLW'(nl);
      step();
      start = 1'b0;
      for (int v = 0; v < 2; v++) begin
         check_eq($sformatf("err_pulse%0d_n%0d", v, nl), 64'(err_o[v]), 64'(1));
         check_eq($sformatf("err_busy%0d_n%0d", v, nl), 64'(busy_o[v]), 64'(0));
      end
      step();
      for (int v = 0; v < 2; v++) begin
         check_eq($sformatf("err_low%0d_n%0d", v, nl), 64'(err_o[v]), 64'(0));
      end
      $display("bad start num_layers=%0d", nl);
   endtask

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      start      = 1'b0;
      rd_ready   = 1'b0;
      wr_valid   = 1'b0;
      num_layers = '0;
      x          = '0;
      w          = '0;
      b          = '0;
      result     = '0;
      mx         = '0;
      for (int l = 0; l < L; l++) begin
         mw[l] = '0;
         mb[l] = '0;
      end
      ey[0] = '0;
      ey[1] = '0;

      // reset state, checked while rst is still asserted
      #3;
      for (int v = 0; v < 2; v++) begin
         check_eq($sformatf("rst_load_ready%0d", v), 64'(load_ready_o[v]), 64'(1));
         check_eq($sformatf("rst_busy%0d", v), 64'(busy_o[v]), 64'(0));
         check_eq($sformatf("rst_rd_valid%0d", v), 64'(rd_valid_o[v]), 64'(0));
         check_eq($sformatf("rst_wr_ready%0d", v), 64'(wr_ready_o[v]), 64'(0));
         check_eq($sformatf("rst_done%0d", v), 64'(done_o[v]), 64'(0));
         check_eq($sformatf("rst_err%0d", v), 64'(err_o[v]), 64'(0));
         check_eq($sformatf("rst_y%0d", v), 64'(y_o[v]), 64'(0));
         check_eq($sformatf("rst_layer_idx%0d", v), 64'(layer_idx_o[v]), 64'(0));
      end
      step();
      rst = 1'b0;
      step();

      // directed two-layer run
      x[0] = 8'h20;
      x[1] = 8'hE0;
      rand_wb();
      load_now();
      res_tab[0][0] = 8'hF0;
      res_tab[0][1] = 8'h10;
      res_tab[1][0] = 8'h30;
      res_tab[1][1] = 8'hD0;
      run(2, 0, 1'b0, 1'b0);
      check_eq("y_directed_relu", 64'(y_o[0]), 64'h0000_D030);
      check_eq("y_directed_pass", 64'(y_o[1]), 64'h0000_D030);

      // long operand stall with a stray wr_valid during ISSUE
      run(2, 5, 1'b1, 1'b0);

      // illegal layer counts
      bad_start(0);
      bad_start(3);

      // single-layer run
      rand_results();
      run(1, 0, 1'b0, 1'b0);

      // load attempt during WAIT is ignored; a rerun reproduces y
      rand_results();
      run(2, 1, 1'b0, 1'b1);
      prev_y = ey[0];
      run(2, 0, 1'b0, 1'b0);
      check_eq("rerun_y_relu", 64'(y_o[0]), 64'(prev_y));
      check_eq("rerun_y_pass", 64'(y_o[1]), 64'(prev_y));

      // load and start together: load wins, no run begins
      x          = rand_vec();
      rand_wb();
      load_valid = 1'b1;
      start      = 1'b1;
      num_layers = NLW'(2);
      step();
      load_valid = 1'b0;
      start      = 1'b0;
      model_take_load();
      for (int v = 0; v < 2; v++) begin
         check_eq($sformatf("ldst_busy%0d", v), 64'(busy_o[v]), 64'(0));
         check_eq($sformatf("ldst_rd_valid%0d", v), 64'(rd_valid_o[v]), 64'(0));
      end
      $display("load+start x=%0h", x);
      rand_results();
      run(2, 0, 1'b0, 1'b0);

      // randomized runs
      for (int t = 0; t < 20; t++) begin
         if ($urandom_range(1) == 1) begin
            x = rand_vec();
            rand_wb();
            load_now();
         end
         rand_results();
         run(int'($urandom_range(L, 1)), int'($urandom_range(3)), 1'($urandom_range(1)), 1'b0);
      end

      // reset during WAIT of layer 1
      start      = 1'b1;
      num_layers = NLW'(2);
      step();
      start    = 1'b0;
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      for (int v = 0; v < 2; v++) begin
         check_eq($sformatf("pre_rst_wr_ready%0d", v), 64'(wr_ready_o[v]), 64'(1));
      end
      #2;
      rst = 1'b1;
      #1;
      for (int v = 0; v < 2; v++) begin
         check_eq($sformatf("midrst_busy%0d", v), 64'(busy_o[v]), 64'(0));
         check_eq($sformatf("midrst_rd_valid%0d", v), 64'(rd_valid_o[v]), 64'(0));
         check_eq($sformatf("midrst_wr_ready%0d", v), 64'(wr_ready_o[v]), 64'(0));
         check_eq($sformatf("midrst_y%0d", v), 64'(y_o[v]), 64'(0));
      end
      $display("reset asserted during WAIT");
      step();
      rst = 1'b0;
      mx  = '0;
      for (int l = 0; l < L; l++) begin
         mw[l] = '0;
         mb[l] = '0;
      end
      for (int c = 0; c < 3; c++) begin
         step();
         for (int v = 0; v < 2; v++) begin
            check_eq($sformatf("postrst_done%0d_c%0d", v, c), 64'(done_o[v]), 64'(0));
         end
      end
      // without a reload the run sees cleared stores
      rand_results();
      run(2, 0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mlp_act_pingpong_mem.md
Name: mlp_act_pingpong_mem

Overview:
- Parametrised activation/weight store for the layer-serial MLP datapath. Sits between the testbench/host loader and the N-neuron MAC array.
- Holds all weights and biases, and ping-pong activation banks.
- Sequences layers with an FSM. Uses valid/ready handshakes to the MAC.
- Supports a runtime layer count and optional ReLU on hidden-layer results.

Parameters:
- L, 2, max number of weight layers stored (L >= 1)
- N, 2, neurons per layer = activations per bank
- QM, 3, activation/bias integer bits
- QN, 5, activation/bias fraction bits
- WM, 3, weight integer bits
- WN, 5, weight fraction bits
- RELU, 1, 1 = apply ReLU to results of all layers except the last; 0 = pass-through

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_valid  in  1  host presents x/w/b this cycle
- load_ready  out  1  store accepts a load (high only in IDLE)
- x  in  [N] x (QM+QN) signed  network input vector
- w  in  [L][N][N] x (WM+WN) signed  weights: layer, neuron, input
- b  in  [L][N] x (QM+QN) signed  biases: layer, neuron
- start  in  1  begin inference (sampled in IDLE)
- num_layers  in  $clog2(L+1)  active layers for this run, legal 1..L
- rd_valid  out  1  inputs/weights/bias for the current layer are valid
- rd_ready  in  1  MAC accepts the read operands
- inputs  out  [N] x (QM+QN) signed  current activation bank
- weights  out  [N][N] x (WM+WN) signed  weights of the current layer
- bias  out  [N] x (QM+QN) signed  biases of the current layer
- wr_valid  in  1  MAC presents the layer result
- wr_ready  out  1  store accepts a result (high only in WAIT)
- result  in  [N] x (QM+QN) signed  MAC outputs
- layer_idx  out  $clog2(L)  (min width 1)  current layer
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse when the final layer has been written
- err  out  1  one-cycle pulse on an illegal start
- y  out  [N] x (QM+QN) signed  final-layer output, held

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; both banks, weight and bias stores, y, layer_idx and sel all cleared to 0.
  - All handshake outputs are 0 except load_ready=1. done=0, err=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - load_ready=1.
  - load_valid: x goes to bank0, w/b to the stores, sel<=0. Stay in IDLE.
  - load_valid and start in the same cycle: the load is taken and start is ignored.
  - start with num_layers in 1..L: latch num_layers, layer_idx<=0, go to ISSUE.
  - start with num_layers==0 or >L: err pulse next cycle, stay in IDLE.
- ISSUE:
  - rd_valid=1. inputs=bank[sel], weights=w[layer_idx], bias=b[layer_idx].
  - Operands are stable until rd_ready. On rd_ready, go to WAIT.
- WAIT:
  - wr_ready=1, rd_valid=0.
  - On wr_valid: write result into bank[~sel] and toggle sel.
  - ReLU: if RELU=1 and this is not the last layer, negative elements are stored as 0.
  - If layer_idx==num_layers-1: also copy the result (never ReLU'd) into y and go to DONE.
  - Otherwise layer_idx++ and go to ISSUE.
- DONE: done=1 for exactly one cycle, then IDLE. y holds until the next completed run.
- Latency:
  - start to rd_valid: 1 cycle.
  - wr_valid accepted to next rd_valid, or to done: 1 cycle.
- Ignored inputs:
  - rd_ready outside ISSUE and wr_valid outside WAIT are ignored, with no state change.
  - load_valid while busy is ignored (load_ready=0). Stored data and banks are untouched.
- Ping-pong: the read bank is never written during a layer. The run always starts from bank0 (x), so rerunning without a reload reproduces the same y.
- Widths: result and bank have equal width, with no arithmetic here. ReLU is a sign-bit test only.
- Reset mid-run: immediate return to IDLE with everything cleared. No done pulse.

Test Plan:
- N=2, L=2, Q3.5. Reset, then load x={0x20,0xE0}. start, num_layers=2. MAC returns {0xF0,0x10}, then {0x30,0xD0}. Required:
  - Layer-1 inputs={0xE0,0x20}... more precisely bank0 as loaded; layer-2 inputs={0x00,0x10} (ReLU applied).
  - y={0x30,0xD0} (no ReLU on the last layer).
  - done high exactly once; busy falls the cycle after done.
- RELU=0, same sequence: layer-2 inputs={0xF0,0x10}.
- Hold rd_ready low for 5 cycles in ISSUE: rd_valid, inputs, weights and bias stay constant. Pulse wr_valid during ISSUE: ignored, layer_idx unchanged.
- start with num_layers=0, then 3 (L=2): err pulses once each, busy stays 0. start with num_layers=1: done after one write, y=result.
- load_valid during WAIT with new x: ignored. A rerun after done gives an identical y. load_valid and start in the same IDLE cycle: the load is taken, busy stays 0.
- Assert rst during WAIT of layer 1: in the same cycle busy=0, rd_valid=0, wr_ready=0, y=0. No done pulse; the next run requires a reload.
